// File: rtl/bp_me_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : bp_me_pkg
// Brief   : Shared types and helpers for the streaming-accelerator coherence
//           arbiter (state encoding, round-robin index wrap).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package bp_me_pkg;

  // Arbiter state: no owner / header offered but stalled / body streaming
  typedef enum logic [1:0] {
    e_arb  = 2'd0,
    e_hold = 2'd1,
    e_lock = 2'd2
  } bp_sacc_arb_state_e;

  // Circular increment of a source index in the range [0, n-1]
  function automatic int rr_wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_sacc_coh_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : bp_sacc_coh_arbiter_if
// Brief   : Bundle of the per-source input streams, the merged output stream
//           and the arbiter status signals. Names are seen from the arbiter.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface bp_sacc_coh_arbiter_if #(
  parameter int num_src_p    = 4,
  parameter int flit_width_p = 128
);

  logic [num_src_p-1:0][flit_width_p-1:0] data_i;
  logic [num_src_p-1:0]                   v_i;
  logic [num_src_p-1:0]                   ready_and_o;
  logic [flit_width_p-1:0]                data_o;
  logic                                   v_o;
  logic                                   ready_and_i;
  logic [num_src_p-1:0]                   grant_o;
  logic                                   locked_o;

  // Arbiter side
  modport slave (
    input  data_i, v_i, ready_and_i,
    output ready_and_o, data_o, v_o, grant_o, locked_o
  );

  // Environment side (sources and downstream sink)
  modport master (
    output data_i, v_i, ready_and_i,
    input  ready_and_o, data_o, v_o, grant_o, locked_o
  );

endinterface
`default_nettype wire

// File: rtl/bp_sacc_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : bp_sacc_rr_pick
// Brief   : Combinational circular priority search. Returns the first valid
//           source found starting at ptr_i and wrapping around.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module bp_sacc_rr_pick
  import bp_me_pkg::*;
#(
  parameter int num_src_p   = 4,
  parameter int idx_width_p = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
  input  logic [num_src_p-1:0]   v_i,
  input  logic [idx_width_p-1:0] ptr_i,
  output logic [num_src_p-1:0]   grant_o,
  output logic [idx_width_p-1:0] idx_o,
  output logic                   v_o
);

  localparam logic [idx_width_p:0] c_num_src = (idx_width_p + 1)'(num_src_p);

  logic [idx_width_p:0]   w_pos;
  logic [idx_width_p-1:0] w_idx;

  // Walk sources from ptr_i circularly; the first valid one wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    v_o     = 1'b0;
    w_pos   = '0;
    w_idx   = '0;
    for (int k = 0; k < num_src_p; k++) begin
      w_pos = {1'b0, ptr_i} + (idx_width_p + 1)'(k);
      if (w_pos >= c_num_src) begin
        w_pos = w_pos - c_num_src;
      end
      w_idx = w_pos[idx_width_p-1:0];
      if (!v_o && v_i[w_idx]) begin
        v_o            = 1'b1;
        idx_o          = w_idx;
        grant_o[w_idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bp_sacc_coh_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : bp_sacc_coh_arbiter
// Brief   : Wormhole-aware round-robin arbiter merging accelerator-node
//           coherence streams onto one ready-and link. A source owns the
//           link for a whole packet (header plus len body flits).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module bp_sacc_coh_arbiter
  import bp_me_pkg::*;
#(
  parameter int num_src_p    = 4,
  parameter int flit_width_p = 128,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  bp_sacc_coh_arbiter_if.slave link
);

  localparam int c_idx_w   = (num_src_p > 1) ? $clog2(num_src_p) : 1;
  // Length field sits directly above the destination coordinate
  localparam int c_len_lsb = cord_width_p;

  bp_sacc_arb_state_e      state_r, state_n;
  logic [c_idx_w-1:0]      owner_r, owner_n;
  logic [c_idx_w-1:0]      ptr_r, ptr_n;
  logic [len_width_p-1:0]  cnt_r, cnt_n;

  logic [num_src_p-1:0]    w_pick_grant;
  logic [c_idx_w-1:0]      w_pick_idx;
  logic                    w_pick_v;

  logic [c_idx_w-1:0]      w_cur_idx;
  logic                    w_cur_v;
  logic [num_src_p-1:0]    w_grant;
  logic [flit_width_p-1:0] w_data;
  logic [len_width_p-1:0]  w_hdr_len;
  logic                    w_hs;

  function automatic logic [c_idx_w-1:0] next_idx(input logic [c_idx_w-1:0] idx);
    return c_idx_w'(rr_wrap_inc(int'(idx), num_src_p));
  endfunction

  bp_sacc_rr_pick #(
    .num_src_p   (num_src_p),
    .idx_width_p (c_idx_w)
  ) u_pick (
    .v_i     (link.v_i),
    .ptr_i   (ptr_r),
    .grant_o (w_pick_grant),
    .idx_o   (w_pick_idx),
    .v_o     (w_pick_v)
  );

  // Pick the driving source: fresh arbitration when idle, else the owner
  always_comb begin
    w_cur_idx          = owner_r;
    w_cur_v            = link.v_i[owner_r];
    w_grant            = '0;
    w_grant[owner_r]   = 1'b1;
    if (state_r == e_arb) begin
      w_cur_idx = w_pick_idx;
      w_cur_v   = w_pick_v;
      w_grant   = w_pick_grant;
    end
  end

  assign w_data    = link.data_i[w_cur_idx];
  assign w_hdr_len = w_data[c_len_lsb +: len_width_p];
  assign w_hs      = w_cur_v & link.ready_and_i;

  // State, owner, pointer and body counter registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_arb;
      owner_r <= '0;
      ptr_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      owner_r <= owner_n;
      ptr_r   <= ptr_n;
      cnt_r   <= cnt_n;
    end
  end

  // Next-state: lock on multi-flit headers, rotate pointer on last flit
  always_comb begin
    state_n = state_r;
    owner_n = owner_r;
    ptr_n   = ptr_r;
    cnt_n   = cnt_r;
    case (state_r)
      e_arb: begin
        if (w_pick_v) begin
          if (link.ready_and_i) begin
            if (w_hdr_len == '0) begin
              ptr_n = next_idx(w_pick_idx);
            end else begin
              owner_n = w_pick_idx;
              cnt_n   = w_hdr_len;
              state_n = e_lock;
            end
          end else begin
            // Freeze the choice so the stalled header cannot be swapped
            owner_n = w_pick_idx;
            state_n = e_hold;
          end
        end
      end
      e_hold: begin
        if (w_hs) begin
          if (w_hdr_len == '0) begin
            ptr_n   = next_idx(owner_r);
            state_n = e_arb;
          end else begin
            cnt_n   = w_hdr_len;
            state_n = e_lock;
          end
        end
      end
      e_lock: begin
        if (w_hs) begin
          cnt_n = cnt_r - len_width_p'(1);
          if (cnt_r == len_width_p'(1)) begin
            ptr_n   = next_idx(owner_r);
            state_n = e_arb;
          end
        end
      end
      default: begin
        state_n = e_arb;
      end
    endcase
  end

  // Outputs; handshake-related signals are held low while reset is asserted
  assign link.data_o      = w_data;
  assign link.v_o         = w_cur_v & reset_n_i;
  assign link.grant_o     = reset_n_i ? w_grant : '0;
  assign link.ready_and_o = w_grant & {num_src_p{link.ready_and_i & reset_n_i}};
  assign link.locked_o    = reset_n_i & (state_r == e_lock);

endmodule
`default_nettype wire

// File: tb/tb_bp_sacc_coh_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_bp_sacc_coh_arbiter
// Brief   : Directed vector table plus a reset-during-lock sequence for the
//           coherence stream arbiter.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_bp_sacc_coh_arbiter;

  localparam int c_n  = 4;
  localparam int c_fw = 128;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bp_sacc_coh_arbiter_if #(.num_src_p(c_n), .flit_width_p(c_fw)) link ();

  bp_sacc_coh_arbiter #(
    .num_src_p    (c_n),
    .flit_width_p (c_fw),
    .cord_width_p (8),
    .len_width_p  (4)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .link      (link)
  );

  typedef struct {
    logic         rstn;
    logic [3:0]   v;
    logic         rdy;
    logic [15:0]  lens;   // len nibble per source, src3..src0
    logic [31:0]  seqs;   // tag byte per source, src3..src0
    logic         ev;
    logic [127:0] edata;
    logic [3:0]   erdy;
    logic [3:0]   egnt;
    logic         el;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [127:0] mk(input int src, input logic [7:0] seq, input logic [3:0] len);
    logic [127:0] f;
    f          = '0;
    f[7:0]     = 8'h10 + 8'(src);
    f[11:8]    = len;
    f[23:16]   = seq;
    f[127:96]  = 32'hC0DE_0000 + 32'(src);
    return f;
  endfunction

  function automatic logic [127:0] flit_of(input int src, input logic [15:0] lens, input logic [31:0] seqs);
    case (src)
      0:       return mk(0, seqs[7:0],   lens[3:0]);
      1:       return mk(1, seqs[15:8],  lens[7:4]);
      2:       return mk(2, seqs[23:16], lens[11:8]);
      default: return mk(3, seqs[31:24], lens[15:12]);
    endcase
  endfunction

  task automatic add(input logic rstn, input logic [3:0] v, input logic rdy,
                     input logic [15:0] lens, input logic [31:0] seqs,
                     input logic ev, input int esrc, input logic [3:0] erdy,
                     input logic [3:0] egnt, input logic el);
    vec_t t;
    t.rstn  = rstn;  t.v = v;  t.rdy = rdy;  t.lens = lens;  t.seqs = seqs;
    t.ev    = ev;
    t.edata = flit_of(esrc, lens, seqs);
    t.erdy  = erdy;  t.egnt = egnt;  t.el = el;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic rstn, input logic [3:0] v, input logic rdy,
                       input logic [15:0] lens, input logic [31:0] seqs);
    rst_n            = rstn;
    link.v_i         = v;
    link.ready_and_i = rdy;
    link.data_i[0]   = flit_of(0, lens, seqs);
    link.data_i[1]   = flit_of(1, lens, seqs);
    link.data_i[2]   = flit_of(2, lens, seqs);
    link.data_i[3]   = flit_of(3, lens, seqs);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic [127:0] edata,
                          input logic [3:0] erdy, input logic [3:0] egnt, input logic el);
    chk({tag, " v_o"},         128'(link.v_o),        128'(ev));
    chk({tag, " ready_and_o"}, 128'(link.ready_and_o), 128'(erdy));
    chk({tag, " grant_o"},     128'(link.grant_o),     128'(egnt));
    chk({tag, " locked_o"},    128'(link.locked_o),    128'(el));
    if (ev) chk({tag, " data_o"}, link.data_o, edata);
  endtask

  initial begin
    drive(1'b0, 4'b0000, 1'b0, 16'h0, 32'h0);

    // A: single len=0 header, then a stalled header and pointer movement
    add(0, 4'b1111, 1, 16'h0000, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0001, 1, 16'h0000, 32'h00000001, 1, 0, 4'b0001, 4'b0001, 0);
    add(1, 4'b0000, 1, 16'h0000, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0011, 0, 16'h0000, 32'h00001002, 1, 1, 4'b0000, 4'b0010, 0);
    add(1, 4'b0011, 1, 16'h0000, 32'h00001002, 1, 1, 4'b0010, 4'b0010, 0);
    add(1, 4'b0001, 1, 16'h0000, 32'h00000002, 1, 0, 4'b0001, 4'b0001, 0);
    // B: src0 and src2 send len=2 packets together, no interleave
    add(0, 4'b0000, 1, 16'h0000, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0101, 1, 16'h0202, 32'h00400020, 1, 0, 4'b0001, 4'b0001, 0);
    add(1, 4'b0101, 1, 16'h020F, 32'h00400021, 1, 0, 4'b0001, 4'b0001, 1);
    add(1, 4'b0101, 1, 16'h020F, 32'h00400022, 1, 0, 4'b0001, 4'b0001, 1);
    add(1, 4'b0100, 1, 16'h0200, 32'h00400000, 1, 2, 4'b0100, 4'b0100, 0);
    add(1, 4'b0100, 1, 16'h0F00, 32'h00410000, 1, 2, 4'b0100, 4'b0100, 1);
    add(1, 4'b0100, 1, 16'h0F00, 32'h00420000, 1, 2, 4'b0100, 4'b0100, 1);
    // C: src1 header stalled 3 cycles while src0 raises valid, then len=3 body
    add(1, 4'b0010, 0, 16'h0030, 32'h00005000, 1, 1, 4'b0000, 4'b0010, 0);
    add(1, 4'b0011, 0, 16'h0030, 32'h00005060, 1, 1, 4'b0000, 4'b0010, 0);
    add(1, 4'b0011, 0, 16'h0030, 32'h00005060, 1, 1, 4'b0000, 4'b0010, 0);
    add(1, 4'b0011, 1, 16'h0030, 32'h00005060, 1, 1, 4'b0010, 4'b0010, 0);
    add(1, 4'b0011, 1, 16'h00F0, 32'h00005160, 1, 1, 4'b0010, 4'b0010, 1);
    add(1, 4'b0011, 1, 16'h00F0, 32'h00005260, 1, 1, 4'b0010, 4'b0010, 1);
    add(1, 4'b0011, 1, 16'h00F0, 32'h00005360, 1, 1, 4'b0010, 4'b0010, 1);
    add(1, 4'b0001, 1, 16'h0000, 32'h00000060, 1, 0, 4'b0001, 4'b0001, 0);
    // D: locked src3 bubbles for 2 cycles mid-body, pointer wraps to 0
    add(1, 4'b1000, 1, 16'h3000, 32'h70000000, 1, 3, 4'b1000, 4'b1000, 0);
    add(1, 4'b1000, 1, 16'hF000, 32'h71000000, 1, 3, 4'b1000, 4'b1000, 1);
    add(1, 4'b0001, 1, 16'hF000, 32'h72000080, 0, 3, 4'b1000, 4'b1000, 1);
    add(1, 4'b0001, 1, 16'hF000, 32'h72000080, 0, 3, 4'b1000, 4'b1000, 1);
    add(1, 4'b1001, 1, 16'hF000, 32'h72000080, 1, 3, 4'b1000, 4'b1000, 1);
    add(1, 4'b1001, 1, 16'hF000, 32'h73000080, 1, 3, 4'b1000, 4'b1000, 1);
    add(1, 4'b1001, 1, 16'h0000, 32'h74000080, 1, 0, 4'b0001, 4'b0001, 0);
    // E: all sources stream len=0 packets, grants rotate
    add(0, 4'b0000, 1, 16'h0000, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b1111, 1, 16'h0000, 32'h04030201, 1, 0, 4'b0001, 4'b0001, 0);
    add(1, 4'b1111, 1, 16'h0000, 32'h04030201, 1, 1, 4'b0010, 4'b0010, 0);
    add(1, 4'b1111, 1, 16'h0000, 32'h04030201, 1, 2, 4'b0100, 4'b0100, 0);
    add(1, 4'b1111, 1, 16'h0000, 32'h04030201, 1, 3, 4'b1000, 4'b1000, 0);
    add(1, 4'b1111, 1, 16'h0000, 32'h04030201, 1, 0, 4'b0001, 4'b0001, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rstn, vecs[i].v, vecs[i].rdy, vecs[i].lens, vecs[i].seqs);
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].edata,
               vecs[i].erdy, vecs[i].egnt, vecs[i].el);
    end

    // F: reset while locked with 4 body flits outstanding
    @(negedge clk);
    drive(1'b1, 4'b0010, 1'b1, 16'h0040, 32'h00009000);
    #1;
    chk_outs("rst_seq hdr", 1'b1, mk(1, 8'h90, 4'h4), 4'b0010, 4'b0010, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'b0010, 1'b0, 16'h00F0, 32'h00009100);
    #1;
    chk_outs("rst_seq locked", 1'b1, mk(1, 8'h91, 4'hF), 4'b0000, 4'b0010, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'b1111, 1'b1, 16'h00F0, 32'h00009100);
    #1;
    chk_outs("rst_seq in_reset", 1'b0, '0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'b0000, 1'b1, 16'h0000, 32'h00000000);
    #1;
    chk_outs("rst_seq released", 1'b0, '0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'b1111, 1'b1, 16'h0000, 32'h0A0B0C0D);
    #1;
    chk_outs("rst_seq first_win", 1'b1, mk(0, 8'h0D, 4'h0), 4'b0001, 4'b0001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bp_sacc_coh_arbiter.md
# bp_sacc_coh_arbiter

Wormhole-aware round-robin arbiter that merges the coherence-NoC output streams of `num_src_p` streaming-accelerator tile nodes onto one ready-and link toward the accelerator complex boundary. It locks onto a source for an entire packet (header plus `len` body flits), so flits from different packets never interleave on the shared link. It sits between the per-row accelerator node outputs and the east-edge `coh_req`/`coh_cmd` link of the accelerator complex; one instance is used per network.

## Interface
- `num_src_p`, default 4: number of requesting sources, at least 2.
- `flit_width_p`, default 128: coherence NoC flit width.
- `cord_width_p`, default 8: width of the header destination-coordinate field, located at `[cord_width_p-1:0]`.
- `len_width_p`, default 4: width of the header length field, located at `[cord_width_p+:len_width_p]`. The field holds the number of body flits after the header.
- `clk_i` in, 1 bit: single clock.
- `reset_n_i` in, 1 bit: synchronous, active-low reset.
- `data_i` in, `num_src_p`×`flit_width_p`: per-source flit.
- `v_i` in, `num_src_p`: per-source valid.
- `ready_and_o` out, `num_src_p`: per-source ready (ready-and protocol).
- `data_o` out, `flit_width_p`: merged flit.
- `v_o` out, 1 bit: merged valid.
- `ready_and_i` in, 1 bit: downstream ready.
- `grant_o` out, `num_src_p`: one-hot owner of the output link. All zero when no source is selected.
- `locked_o` out, 1 bit: high while the arbiter is inside a packet body.

## Operation
- States:
  - `e_arb`: no owner.
  - `e_hold`: a header has been offered but not yet accepted.
  - `e_lock`: body flits of the owner are streaming.
- Registers: `state_r`, `owner_r` (index), `ptr_r` (round-robin pointer), `cnt_r` (`len_width_p` bits).
- In `e_arb`:
  - The selection is the first source with `v_i` set, searching circularly from `ptr_r`.
  - `v_o` is the OR of `v_i`.
  - `data_o`, `grant_o` and `ready_and_o[sel]` follow the selection combinationally. `ready_and_o[sel]` equals `ready_and_i`.
- Header offered and accepted in the same cycle (`v_o & ready_and_i`):
  - `len==0`: stay in `e_arb`; `ptr_r` becomes `sel+1` (mod `num_src_p`).
  - `len>0`: `owner_r` gets `sel`, `cnt_r` gets `len`, go to `e_lock`.
- Header offered but not accepted (`v_o & ~ready_and_i`): `owner_r` gets `sel`, go to `e_hold`. This keeps the offered header stable on `data_o` even if a higher-priority source asserts valid.
- In `e_hold`, the output is driven only from `owner_r`. On acceptance, apply the same `len` rule as in `e_arb`.
- In `e_lock`:
  - The output is driven only from `owner_r`, with `v_o = v_i[owner_r]`.
  - Each handshake decrements `cnt_r`.
  - The handshake with `cnt_r==1` returns to `e_arb` and sets `ptr_r` to `owner_r+1`.
  - If the owner drops `v_i` mid-packet, `v_o=0` (a bubble) and the lock is held.
- Non-owners always see `ready_and_o=0`. `ready_and_o` never depends on a non-selected `v_i`.
- `locked_o` is high exactly when `state_r==e_lock`.
- Sources must hold `v_i`/`data_i` until handshake. The arbiter does not check this.
- `ptr_r` changes only on the last flit of a packet, whether a single-flit header or the final body flit.

## Timing
- Zero-latency combinational pass-through, with no flit storage.
- A handshake occurs in a cycle where `v_o & ready_and_i`. State updates at the next `clk_i` edge.
- Back-to-back packets: the arbitration for the next header happens in the same cycle that follows the final flit. No dead cycle is inserted.
- Reset (`reset_n_i=0` at a clock edge):
  - `state_r=e_arb`, `ptr_r=0`, `owner_r=0`, `cnt_r=0`.
  - While reset is low, `v_o`, `ready_and_o`, `grant_o` and `locked_o` are forced to 0 combinationally.
- Reset mid-packet discards the lock immediately. Upstream and downstream are reset together.
- Max packet is `2^len_width_p - 1` body flits. `len` wrap-around is not possible because the counter is loaded, never incremented.

## Structure
- Shared package `bp_me_pkg` gets `typedef enum logic [1:0] {e_arb, e_hold, e_lock} bp_sacc_arb_state_e`.
- The header length-field offset is derived from `cord_width_p` via a localparam in the module.
- Sub-module `bp_sacc_rr_pick`: combinational circular priority search (inputs `v_i` and `ptr_i`; outputs a one-hot grant, an index, and an any-valid flag). It is reused by the `e_arb` path.

## Test plan
- Single source 0 sends a header with `len=0` and `ready_and_i=1` → one-cycle transfer, `ptr_r` becomes 1, `locked_o` stays 0.
- Sources 0 and 2 each send `len=2` packets simultaneously with `ready_and_i=1` → output order is src0 H,B,B then src2 H,B,B, with no interleave and no gap. `grant_o` is 0001 for 3 cycles, then 0100.
- Source 1 offers a header with `ready_and_i=0` for 3 cycles while source 0 raises valid in cycle 2 → `data_o` stays src1's header throughout. On acceptance, src1 is locked (`len=3`).
- Locked source 3 deasserts `v_i` for 2 cycles mid-body with `cnt_r=2` → `v_o=0` for those 2 cycles, other sources' `ready_and_o=0`, and the remaining flits complete from src3.
- All 4 sources continuously send `len=0` packets → grants rotate 0,1,2,3,0 over five cycles.
- `reset_n_i` is pulled low during `e_lock` with `cnt_r=4` → the next cycle shows `state_r=e_arb` and `v_o=0`. After release, source 0 wins first.
